// File: rtl/hamming_scrub_pkg.sv
// Shared types and Hamming(7,4) nibble helpers for the background counter scrubber.
package hamming_scrub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIX  = 2'd2
  } scrub_state_e;

  localparam logic [1:0] EVT_KIND_NONE = 2'b00;
  localparam logic [1:0] EVT_KIND_DATA = 2'b01;
  localparam logic [1:0] EVT_KIND_PAR  = 2'b10;

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] block;
    logic [2:0] syn;
  } scrub_evt_t;

  function automatic logic [2:0] nibble_parity(input logic [3:0] d);
    return {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
  endfunction

  function automatic logic [2:0] nibble_syndrome(input logic [3:0] d, input logic [2:0] p);
    return p ^ nibble_parity(d);
  endfunction

  // Returns {d, p} with the single bit named by the syndrome flipped.
  function automatic logic [6:0] nibble_correct(input logic [2:0] syn, input logic [3:0] d,
                                                input logic [2:0] p);
    logic [3:0] d_fix;
    logic [2:0] p_fix;
    d_fix = d;
    p_fix = p;
    case (syn)
      3'b111:  d_fix[0] = ~d[0];
      3'b011:  d_fix[1] = ~d[1];
      3'b101:  d_fix[2] = ~d[2];
      3'b110:  d_fix[3] = ~d[3];
      3'b001:  p_fix[0] = ~p[0];
      3'b010:  p_fix[1] = ~p[1];
      3'b100:  p_fix[2] = ~p[2];
      default: begin
        d_fix = d;
        p_fix = p;
      end
    endcase
    return {d_fix, p_fix};
  endfunction

  function automatic logic [1:0] syndrome_kind(input logic [2:0] syn);
    logic [1:0] kind;
    case (syn)
      3'b000:                 kind = EVT_KIND_NONE;
      3'b001, 3'b010, 3'b100: kind = EVT_KIND_PAR;
      default:                kind = EVT_KIND_DATA;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/scrub_evt_fifo.sv
// Event log FIFO for the scrubber: DEPTH (power of two, >= 2) entries of DW bits.
// A pop and a push in the same cycle both succeed, including when full.
module scrub_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [DW-1:0] o_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == {(AW + 1){1'b0}});
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DW{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW + 1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hamming_scrubber.sv
// Background Hamming(7,4) scrubber for the event counter and its parity store.
// Define HAMMING_SCRUB_LOG_EN to build the per-block error event log.
module hamming_scrubber
  import hamming_scrub_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BLOCKS         = WIDTH / 4,
  parameter int PARITY_BITS    = BLOCKS * 3,
  parameter int SCRUB_INTERVAL = 64,
  parameter int EVT_DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   idle,
  input  logic                   scan_req,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [PARITY_BITS-1:0] parity_in,
  output logic                   fix_valid,
  input  logic                   fix_ready,
  output logic [WIDTH-1:0]       fix_data,
  output logic [PARITY_BITS-1:0] fix_parity,
  output logic                   scan_busy,
  output logic                   scan_abort,
  output logic [15:0]            corr_count,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [7:0]             evt_data,
  output logic                   evt_overflow
);

  localparam int IDX_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int TMR_W = $clog2(SCRUB_INTERVAL);
  localparam int DB_W  = $clog2(WIDTH);
  localparam int PB_W  = $clog2(PARITY_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCKS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCRUB_INTERVAL - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  scrub_state_e           r_state;
  scrub_state_e           w_next_state;
  logic [IDX_W-1:0]       r_idx;
  logic [TMR_W-1:0]       r_timer;
  logic                   r_err_any;
  logic [WIDTH-1:0]       r_fix_data;
  logic [PARITY_BITS-1:0] r_fix_parity;
  logic [15:0]            r_corr_count;
  logic                   r_fix_valid;
  logic                   r_scan_busy;
  logic                   r_scan_abort;

  logic                   w_start;
  logic                   w_abort;
  logic                   w_proc;
  logic                   w_last;
  logic [DB_W-1:0]        w_dbase;
  logic [PB_W-1:0]        w_pbase;
  logic [3:0]             w_nib;
  logic [2:0]             w_par;
  logic [2:0]             w_syn;
  logic [6:0]             w_fixed;
  logic                   w_blk_err;

  assign w_start   = (r_state == ST_IDLE) & idle & (scan_req | (r_timer == TMR_LAST));
  assign w_abort   = (r_state != ST_IDLE) & ~idle;
  // A block is only trusted while the counter is idle; the abort cycle evaluates nothing.
  assign w_proc    = (r_state == ST_SCAN) & idle;
  assign w_last    = (r_idx == LAST_IDX);
  assign w_dbase   = DB_W'({r_idx, 2'b00});
  assign w_pbase   = PB_W'({r_idx, 1'b0}) + PB_W'(r_idx);
  assign w_nib     = data_in[w_dbase +: 4];
  assign w_par     = parity_in[w_pbase +: 3];
  assign w_syn     = nibble_syndrome(w_nib, w_par);
  assign w_fixed   = nibble_correct(w_syn, w_nib, w_par);
  assign w_blk_err = |w_syn;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next_state = ST_SCAN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!idle) begin
          w_next_state = ST_IDLE;
        end else if (w_last) begin
          w_next_state = (r_err_any | w_blk_err) ? ST_FIX : ST_IDLE;
        end else begin
          w_next_state = ST_SCAN;
        end
      end
      ST_FIX: begin
        if (!idle || fix_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_FIX;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Interval timer, block walk, corrected word and error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer      <= {TMR_W{1'b0}};
      r_idx        <= {IDX_W{1'b0}};
      r_err_any    <= 1'b0;
      r_fix_data   <= {WIDTH{1'b0}};
      r_fix_parity <= {PARITY_BITS{1'b0}};
      r_corr_count <= 16'h0000;
    end else begin
      if ((r_state == ST_IDLE) && idle && !w_start) begin
        r_timer <= r_timer + TMR_ONE;
      end else begin
        r_timer <= {TMR_W{1'b0}};
      end
      if (w_start) begin
        r_idx     <= {IDX_W{1'b0}};
        r_err_any <= 1'b0;
      end else if (w_proc) begin
        r_idx     <= w_last ? r_idx : r_idx + IDX_ONE;
        r_err_any <= r_err_any | w_blk_err;
      end
      if (w_proc) begin
        r_fix_data[w_dbase +: 4]   <= w_fixed[6:3];
        r_fix_parity[w_pbase +: 3] <= w_fixed[2:0];
      end
      if (w_proc && w_blk_err && (r_corr_count != 16'hFFFF)) begin
        r_corr_count <= r_corr_count + 16'h0001;
      end
    end
  end

  // Status flags follow the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fix_valid  <= 1'b0;
      r_scan_busy  <= 1'b0;
      r_scan_abort <= 1'b0;
    end else begin
      r_fix_valid  <= (w_next_state == ST_FIX);
      r_scan_busy  <= (w_next_state != ST_IDLE);
      r_scan_abort <= w_abort;
    end
  end

  assign fix_valid  = r_fix_valid;
  assign fix_data   = r_fix_data;
  assign fix_parity = r_fix_parity;
  assign scan_busy  = r_scan_busy;
  assign scan_abort = r_scan_abort;
  assign corr_count = r_corr_count;

`ifdef HAMMING_SCRUB_LOG_EN
  scrub_evt_t w_evt;
  logic       w_evt_push;
  logic       w_evt_pop;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic [7:0] w_fifo_data;
  logic       r_evt_overflow;

  assign w_evt      = {syndrome_kind(w_syn), 3'(r_idx), w_syn};
  assign w_evt_push = w_proc & w_blk_err;
  assign w_evt_pop  = evt_ready & ~w_fifo_empty;

  scrub_evt_fifo #(
    .DEPTH(EVT_DEPTH),
    .DW   (8)
  ) u_evt_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_evt_push),
    .i_data (w_evt),
    .i_pop  (evt_ready),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty),
    .o_data (w_fifo_data)
  );

  // Sticky record of an event lost to a full log.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_evt_overflow <= 1'b0;
    end else if (w_evt_push && w_fifo_full && !w_evt_pop) begin
      r_evt_overflow <= 1'b1;
    end else begin
      r_evt_overflow <= r_evt_overflow;
    end
  end

  assign evt_valid    = ~w_fifo_empty;
  assign evt_data     = w_fifo_data;
  assign evt_overflow = r_evt_overflow;
`else
  localparam int EVT_DEPTH_UNUSED = EVT_DEPTH;
  logic w_unused_evt_ready;

  assign w_unused_evt_ready = evt_ready;
  assign evt_valid          = 1'b0;
  assign evt_data           = 8'h00;
  assign evt_overflow       = 1'b0;
`endif

endmodule

// File: doc/hamming_scrubber.md
# hamming_scrubber

Background scrubber for the Hamming(7,4)-protected 32-bit event counter. It sits downstream of the counter/parity store and reads the live counter word and the stored parity word while the counter is idle. It walks the eight nibble blocks, computes each block's syndrome and builds a corrected word. When any block is in error, it returns that word to the store over a valid/ready write-back port and optionally logs per-block error events.

## Interface
Parameters:
- WIDTH, 32, protected data width; must be a multiple of 4.
- BLOCKS, WIDTH/4, number of nibble blocks.
- PARITY_BITS, BLOCKS*3, stored parity width.
- SCRUB_INTERVAL, 64, number of idle cycles between automatic scans; must be ≥2.
- EVT_DEPTH, 4, event FIFO depth; must be a power of two.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- idle  in  1  counter is not counting; data and parity are stable.
- scan_req  in  1  single-cycle pulse that starts a scan immediately if idle=1.
- data_in  in  WIDTH  live counter word.
- parity_in  in  PARITY_BITS  stored parity word.
- fix_valid  out  1  corrected word is available.
- fix_ready  in  1  store accepts the corrected word.
- fix_data  out  WIDTH  corrected counter word.
- fix_parity  out  PARITY_BITS  corrected parity word.
- scan_busy  out  1  FSM is in SCAN or FIX.
- scan_abort  out  1  one-cycle pulse when a scan or fix is abandoned.
- corr_count  out  16  saturating count of erroneous blocks detected.
- evt_valid  out  1  event FIFO is not empty.
- evt_ready  in  1  pop the event FIFO.
- evt_data  out  8  event word {kind[1:0], block[2:0], syn[2:0]}.
- evt_overflow  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- Block i covers data d = data_in[4i+3:4i] and parity p = parity_in[3i+2:3i].
- Parity equations:
  - p[2] = d0^d2^d3
  - p[1] = d0^d1^d3
  - p[0] = d0^d1^d2
- Syndrome s[k] = p[k] XOR the same equation over d.
- Syndrome decode:
  - 111 → flip d0
  - 011 → flip d1
  - 101 → flip d2
  - 110 → flip d3
  - 001, 010, 100 → flip the matching parity bit
  - 000 → no change
- Double errors within a block are miscorrected. This is accepted; the code only guarantees single-error correction per block.
- FSM states:
  - IDLE: the interval timer counts while idle=1 and clears when idle=0. When the timer reaches SCRUB_INTERVAL-1, or when scan_req=1 with idle=1, go to SCAN and clear the block index.
  - SCAN: process one block per cycle, index 0 to BLOCKS-1. Write the corrected nibble and parity into the fix_data/fix_parity registers, and OR in err_any. After the last block, go to FIX if err_any=1; otherwise go to IDLE.
  - FIX: fix_valid=1 and fix_data/fix_parity are held stable. When fix_valid && fix_ready, go to IDLE.
- In every state, idle=0 while in SCAN or FIX sends the FSM to IDLE, pulses scan_abort and drops fix_valid the next cycle. This is the only permitted withdrawal of fix_valid. Detected events and corr_count updates are not rolled back.
- Every block with non-zero syndrome:
  - increments corr_count (saturating at 0xFFFF);
  - pushes an event with kind 01 for a data-bit fix or kind 10 for a parity-bit fix.
- A push while the FIFO is full drops the event and sets evt_overflow. Only reset clears evt_overflow.
- When the FIFO is full, a pop and a push in the same cycle both succeed.
- The interval timer clears on leaving FIX or SCAN.

## Timing
- Reset values:
  - FSM = IDLE; timer, index and err_any = 0.
  - fix_valid, scan_busy, scan_abort = 0.
  - fix_data, fix_parity, corr_count = 0.
  - FIFO empty; evt_valid, evt_data, evt_overflow = 0.
- A reset asserted mid-operation returns the block to this state immediately.
- Scan start: one cycle after the trigger, scan_busy=1. Block i is evaluated in SCAN cycle i.
- fix_valid rises in the cycle after the last SCAN cycle, i.e. BLOCKS+1 cycles after the trigger.
- An event for block i becomes visible on evt_valid one cycle after its SCAN cycle when the FIFO was empty. evt_data is registered FIFO head.
- A scan_req arriving during SCAN or FIX is ignored.

## Configuration
- HAMMING_SCRUB_LOG_EN defined: the event FIFO, evt_valid, evt_data and evt_overflow are implemented as described.
- HAMMING_SCRUB_LOG_EN undefined: no FIFO is instantiated. evt_valid, evt_data and evt_overflow are tied to 0 and evt_ready is ignored. corr_count and correction behave identically.

## Structure
- Package hamming_scrub_pkg holds:
  - state enum (IDLE, SCAN, FIX);
  - event kind constants;
  - event struct;
  - function nibble_syndrome(d, p);
  - function nibble_correct(syn, d, p).
- One sub-module: scrub_evt_fifo, a synchronous FIFO of depth EVT_DEPTH with full/empty flags and simultaneous push/pop support.

## Test plan
- data_in=0x12345678, correct parity, scan_req pulse with idle=1 → 8 SCAN cycles, no fix_valid, corr_count=0, no events.
- Same word with bit 9 flipped (block 2, d1) → fix_valid at cycle 9, fix_data=0x12345678, parity unchanged, event {01,010,011}, corr_count=1.
- parity_in bit 0 flipped (block 0, p0) → fix_parity restored, fix_data unchanged, event {10,000,001}.
- Single-bit errors in 6 blocks, evt_ready=0 → 4 events retained, evt_overflow=1, corr_count=6.
- idle dropped in SCAN cycle 3, and separately during FIX with fix_ready=0 → scan_abort pulse, fix_valid=0 next cycle, FSM in IDLE.
- idle held high with no scan_req → automatic scan starts after 64 cycles; reset asserted mid-scan → all outputs return to reset values.
